// File: rtl/mem_reader_pkg.sv
// Shared definitions for the burst memory reader: default sizes, length
// saturation limit and FSM state encoding.
package mem_reader_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;
  localparam int unsigned LEN_SAT    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_reader.sv
// Burst reader: walks a combinational-read memory from base_addr for up to
// LEN_SAT words and streams them out over a valid/ready handshake.
module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] SAT_LEN = (ADDR_W + 1)'(LEN_SAT);
  localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            rd_addr_d   = base_addr;
            remaining_d = (length > SAT_LEN) ? SAT_LEN : length;
            state_d     = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
        out_last_d  = (remaining_q == ONE_LEN);
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = ST_DONE;
          end else begin
            rd_addr_d   = rd_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - ONE_LEN;
            state_d     = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // busy/done follow the next state so they line up with state_q as registers
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader against a preloaded mem[i] = 8'h10 + i.
module tb_mem_reader;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  mem_reader #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitor: scoreboard pops on accepted words, stall-hold checks, done counting
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 32'(out_data), 32'(e.data));
          check("word_last", 32'(out_last), 32'(e.last));
          check("word_addr", 32'(rd_addr), 32'(e.addr));
        end
        acc_cnt++;
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_expected(input int base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = AW'((base + i) % 16);
      e.data = DW'(8'h10 + ((base + i) % 16));
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_burst(input int base, input int len, input int stall_word,
                           input int stall_cycles, input bit spam_start);
    int n;
    int acc0;
    int dc0;
    int stall_left;
    int k;
    int first_v;
    int done_k;
    n          = (len > 16) ? 16 : len;
    acc0       = acc_cnt;
    dc0        = done_cnt;
    stall_left = stall_cycles;
    k          = 0;
    first_v    = -1;
    done_k     = -1;
    push_expected(base, n);
    start     = 1'b1;
    base_addr = AW'(base);
    length    = (AW + 1)'(len);
    out_ready = 1'b1;
    while (k < 200 && done_k < 0) begin
      @(posedge clk);
      #1;
      k++;
      start = spam_start && (k % 2 == 1);
      if (out_valid && first_v < 0) first_v = k;
      if (done) done_k = k;
      if (out_valid && (acc_cnt - acc0) == stall_word && stall_left > 0) begin
        out_ready  = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
    check("done_cycle", done_k, 2 * n + 1 + stall_cycles);
    if (n > 0) check("first_valid_lat", first_v, 2);
    check("busy_in_done", 32'(busy), 32'd1);
    // start held high in the DONE cycle must be ignored
    start = spam_start;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_width", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("done_count", done_cnt - dc0, 1);
    check("sb_drained", exp_q.size(), 0);
    check("words_accepted", acc_cnt - acc0, n);
    if (n > 0) check("rd_addr_hold", 32'(rd_addr), (base + n - 1) % 16);
    @(posedge clk);
    #1;
    check("idle_no_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic reset_mid_burst();
    int acc0;
    int dc0;
    int k;
    acc0 = acc_cnt;
    dc0  = done_cnt;
    k    = 0;
    push_expected(0, 8);
    start     = 1'b1;
    base_addr = '0;
    length    = (AW + 1)'(8);
    out_ready = 1'b1;
    while (k < 100 && !(out_valid && (acc_cnt - acc0) == 2)) begin
      @(posedge clk);
      #1;
      k++;
      start = 1'b0;
    end
    out_ready = 1'b0;
    check("rst_reach_word3", acc_cnt - acc0, 2);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt - dc0, 0);
    check("rst_stays_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(8'h10 + i);
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_burst(3, 4, -1, 0, 1'b0);
    run_burst(14, 4, -1, 0, 1'b0);
    run_burst(0, 4, 1, 5, 1'b0);
    run_burst(0, 0, -1, 0, 1'b0);
    run_burst(0, 20, -1, 0, 1'b0);
    run_burst(9, 1, 0, 2, 1'b0);
    run_burst(10, 16, 15, 3, 1'b0);
    reset_mid_burst();
    run_burst(5, 2, -1, 0, 1'b0);
    run_burst(7, 3, -1, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width of the weight memory.
REQ-002 SHALL have parameter ADDR_W, default 4, memory address width; DEPTH = 2**ADDR_W = 16.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a burst read.
REQ-006 SHALL have port base_addr, input, ADDR_W, first memory address of the burst, sampled with start.
REQ-007 SHALL have port length, input, ADDR_W+1, number of words to read (0..31), sampled with start.
REQ-008 SHALL have port rd_addr, output, ADDR_W, address driven to the memory's addr input.
REQ-009 SHALL have port rd_data, input, DATA_W, memory's combinational read data (packet) for rd_addr.
REQ-010 SHALL have port out_data, output, DATA_W, streamed word.
REQ-011 SHALL have port out_valid, output, 1, out_data holds a valid word.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the word when high with out_valid.
REQ-013 SHALL have port out_last, output, 1, high with out_valid on the final word of the burst.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, SEND, DONE; all outputs registered.
REQ-017 In IDLE with start=1 and length>=1: latch rd_addr<=base_addr, remaining<=min(length,16), go FETCH.
REQ-018 In IDLE with start=1 and length=0: go DONE directly, no word emitted.
REQ-019 length values 17..31 SHALL saturate to 16; no address is read twice within one burst.
REQ-020 FETCH: capture rd_data into out_data, set out_valid=1, out_last=(remaining==1), go SEND; FETCH lasts exactly one cycle.
REQ-021 SEND: out_data, out_valid, out_last SHALL hold stable while out_ready=0.
REQ-022 SEND with out_ready=1 and out_last=1: clear out_valid/out_last, go DONE.
REQ-023 SEND with out_ready=1 and out_last=0: clear out_valid, rd_addr<=rd_addr+1 modulo 16 (15 wraps to 0), remaining<=remaining-1, go FETCH.
REQ-024 Latency: start at cycle N gives first out_valid at cycle N+2; with out_ready held high, one word per 2 cycles.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; busy deasserts in the IDLE cycle.
REQ-026 start while busy=1 SHALL be ignored, including in DONE.
REQ-027 rd_addr SHALL hold its last value in IDLE; block never writes the memory.

Reset
REQ-028 On rst=1 at a clock edge, state<=IDLE, rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, remaining=0.
REQ-029 Reset mid-burst SHALL abandon the burst with no done pulse; rst has priority over start.

Structure
REQ-030 SHALL place the state enum, DATA_W/ADDR_W/DEPTH defaults and the length saturation constant (16) in shared package mem_reader_pkg.
REQ-031 SHALL be a single module with no sub-modules; the memory is instantiated beside it by the parent, not inside.

Verification
REQ-032 Memory preloaded mem[i]=8'h10+i; base=3, length=4, out_ready=1 -> words 13,14,15,16, out_last on 16, done 1 cycle after last accept.
REQ-033 base=14, length=4 -> rd_addr sequence 14,15,0,1; words 1E,1F,10,11.
REQ-034 base=0, length=4, out_ready low 5 cycles on the 2nd word -> out_data=11 held stable with out_valid=1 for all 5 cycles, no word lost or duplicated.
REQ-035 length=0 -> no out_valid, done pulse 1 cycle after start; length=20, base=0 -> exactly 16 words 10..1F.
REQ-036 rst=1 during SEND of 3rd word -> next cycle all outputs 0, busy=0, no done; new start afterwards runs a clean burst.
REQ-037 start pulsed repeatedly during a burst of length 3 -> exactly 3 words and one done pulse.
